regbank_onehot: RTL and testbench
=================================

# regbank_onehot

Parametrised register bank: N registers of K bits, one write port and two read ports, all selected one-hot. Generalises the existing load-enable register and one-hot read multiplexers into a single block. Adds asynchronous reset, illegal-select detection with a sticky error flag, and optional write-to-read bypass. Sits in the datapath as the general-purpose register file, between the instruction decoder (which drives the selects) and the ALU operand inputs.

## Interface
- K, 16, register and data width in bits (≥1)
- N, 8, number of registers; also the width of every select bus (2..32)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all registers and sel_err
- write  in  1  write enable for this cycle
- wsel  in  N  one-hot write select
- wdata  in  K  write data
- rsel_a  in  N  one-hot read select, port A
- rsel_b  in  N  one-hot read select, port B
- rdata_a  out  K  read data, port A (combinational)
- rdata_b  out  K  read data, port B (combinational)
- err_clr  in  1  synchronous clear of sel_err
- sel_err  out  1  sticky illegal-select flag (registered)

## Operation
- Storage: N registers R[0..N-1]. All reset to 0 while reset=1, independent of clk.
- Write: on a rising edge with write=1 and wsel exactly one-hot at bit i, R[i] <= wdata. All other registers hold.
- Illegal write: write=1 and wsel is all-zero or multi-hot. No register changes and sel_err sets.
- write=0: wsel is ignored, no error.
- Read: rdata_x = R[i] when rsel_x is one-hot at bit i.
  - rsel_x all-zero is idle: rdata_x = 0, no error.
  - rsel_x multi-hot: rdata_x = 0 and sel_err sets.
- Output is never X.
- sel_err next-state:
  - 1 if any illegal condition exists this cycle.
  - else 0 if err_clr=1.
  - else holds.
  - A new error in the same cycle as err_clr wins, so sel_err stays 1.
- Both read ports may select the same register; both return the same value.

## Timing
- Read latency: 0 cycles from select change (combinational path from register and select to rdata).
- Write latency: 1 edge. Without bypass, a read of the written register shows the new value in the cycle after the edge.
- sel_err rises on the edge following the illegal cycle. It falls on the edge after err_clr, provided no error occurs in that cycle.
- Reset asserted mid-cycle: registers and sel_err go to 0 immediately. A pending write in that cycle is discarded. The first write can take effect at the first rising edge after reset deasserts.
- Reset values: rdata_a = rdata_b = 0 for any legal or idle select; sel_err = 0.

## Configuration
- REGBANK_BYPASS_EN defined:
  - When write=1, wsel is legal at bit i, and rsel_x selects bit i in the same cycle, rdata_x = wdata combinationally (write-first).
  - Illegal writes never bypass.
- REGBANK_BYPASS_EN undefined: rdata_x always reflects stored contents (read-before-write). No wdata→rdata path exists.

## Structure
- Package regbank_pkg holds:
  - default constants REGBANK_K=16 and REGBANK_N=8
  - a function onehot_legal(sel) returning {is_zero, is_onehot} for N-bit selects
- Sub-module onehot_rdmux (parameters K, N):
  - AND-OR one-hot read mux over the flattened register array
  - outputs rdata and a multi-hot flag
  - instantiated once per read port
- Top level owns the register array, write decode, bypass logic and sel_err flop.

## Test plan
K=16, N=8 for all scenarios.

- Reset: assert reset with registers holding nonzero values, select rsel_a=8'h04 → rdata_a=16'h0000 and sel_err=0 immediately, before any clk edge.
- Write then read: write=1, wsel=8'h08, wdata=16'hBEEF; next cycle rsel_a=8'h08, rsel_b=8'h08 → both ports read 16'hBEEF.
- Same-cycle read of the register being written (R[3] holds 16'h1111, writing 16'h2222):
  - with REGBANK_BYPASS_EN → rdata_a=16'h2222
  - without → rdata_a=16'h1111, then 16'h2222 after the edge
- Illegal write: write=1, wsel=8'h06, wdata=16'hFFFF → R[1] and R[2] unchanged; sel_err=1 after the edge and remains 1 for 3 idle cycles.
- Error clear race:
  - err_clr=1 together with rsel_b=8'h81 → sel_err stays 1, rdata_b=0
  - next cycle err_clr=1 with legal selects → sel_err=0 after the edge
- Reset mid-write: write=1, wsel=8'h01, wdata=16'h1234, reset pulsed before the edge → R[0] reads 16'h0000 after reset release.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared constants and helpers for the one-hot register bank.
//   REGBANK_K    default register/data width
//   REGBANK_N    default register count (and select bus width)
//   onehot_legal classifies a select bus (zero-extended to 32 bits) as
//                {is_zero, is_onehot}; multi-hot is neither.
package regbank_pkg;

  localparam int unsigned REGBANK_K = 16;
  localparam int unsigned REGBANK_N = 8;

  function automatic logic [1:0] onehot_legal(input logic [31:0] sel);
    logic is_zero;
    logic is_onehot;
    is_zero   = (sel == 32'd0);
    // Clearing the lowest set bit leaves zero only for a single set bit.
    is_onehot = !is_zero && ((sel & (sel - 32'd1)) == 32'd0);
    return {is_zero, is_onehot};
  endfunction

endpackage

// File: rtl/regbank_onehot_rdmux.sv
// One-hot AND-OR read multiplexer over a flattened register array.
// Ports:
//   regs_flat  in  N*K  register contents, register i at [i*K +: K]
//   sel        in  N    one-hot read select (all-zero = idle)
//   rdata      out K    selected register; zero when idle or multi-hot
//   multi_hot  out 1    select has more than one bit set
module onehot_rdmux
  import regbank_pkg::*;
#(
  parameter int unsigned K = REGBANK_K,
  parameter int unsigned N = REGBANK_N
) (
  input  logic [N*K-1:0] regs_flat,
  input  logic [N-1:0]   sel,
  output logic [K-1:0]   rdata,
  output logic           multi_hot
);

  logic [K-1:0] rdata_or;
  logic [1:0]   sel_chk;

  always_comb begin
    rdata_or = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rdata_or = rdata_or | (regs_flat[i*K +: K] & {K{sel[i]}});
    end
  end

  assign sel_chk   = onehot_legal(32'(sel));
  assign multi_hot = ~sel_chk[1] & ~sel_chk[0];
  // Multi-hot would OR several registers together; force a clean zero instead.
  assign rdata     = multi_hot ? '0 : rdata_or;

endmodule

// File: rtl/regbank_onehot.sv
// General-purpose register file: N registers of K bits, one-hot write port and
// two one-hot combinational read ports, sticky illegal-select flag.
// Optional feature macro: REGBANK_BYPASS_EN (write-first bypass of wdata onto a
// read port selecting the register being legally written this cycle).
// Ports:
//   clk      in  1  rising-edge clock
//   reset    in  1  asynchronous active-high; clears registers and sel_err
//   write    in  1  write enable
//   wsel     in  N  one-hot write select
//   wdata    in  K  write data
//   rsel_a   in  N  one-hot read select, port A
//   rsel_b   in  N  one-hot read select, port B
//   rdata_a  out K  read data, port A
//   rdata_b  out K  read data, port B
//   err_clr  in  1  synchronous clear of sel_err
//   sel_err  out 1  sticky illegal-select flag
module regbank_onehot
  import regbank_pkg::*;
#(
  parameter int unsigned K = REGBANK_K,
  parameter int unsigned N = REGBANK_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         write,
  input  logic [N-1:0] wsel,
  input  logic [K-1:0] wdata,
  input  logic [N-1:0] rsel_a,
  input  logic [N-1:0] rsel_b,
  output logic [K-1:0] rdata_a,
  output logic [K-1:0] rdata_b,
  input  logic         err_clr,
  output logic         sel_err
);

  logic [K-1:0]   regs_q [N];
  logic [N*K-1:0] regs_flat;
  logic [1:0]     wsel_chk;
  logic           wr_legal;
  logic           wr_illegal;
  logic [K-1:0]   mux_a;
  logic [K-1:0]   mux_b;
  logic           multi_a;
  logic           multi_b;
  logic           sel_err_q;
  logic           sel_err_d;

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < N; i++) begin
      regs_flat[i*K +: K] = regs_q[i];
    end
  end

  assign wsel_chk   = onehot_legal(32'(wsel));
  assign wr_legal   = write & wsel_chk[0];
  assign wr_illegal = write & ~wsel_chk[0];

  onehot_rdmux #(
    .K (K),
    .N (N)
  ) u_rdmux_a (
    .regs_flat (regs_flat),
    .sel       (rsel_a),
    .rdata     (mux_a),
    .multi_hot (multi_a)
  );

  onehot_rdmux #(
    .K (K),
    .N (N)
  ) u_rdmux_b (
    .regs_flat (regs_flat),
    .sel       (rsel_b),
    .rdata     (mux_b),
    .multi_hot (multi_b)
  );

`ifdef REGBANK_BYPASS_EN
  // A legal wsel is one-hot, so equality means the read hits the written register.
  assign rdata_a = (wr_legal && (rsel_a == wsel)) ? wdata : mux_a;
  assign rdata_b = (wr_legal && (rsel_b == wsel)) ? wdata : mux_b;
`else
  assign rdata_a = mux_a;
  assign rdata_b = mux_b;
`endif

  // A new error outranks a simultaneous clear.
  always_comb begin
    sel_err_d = sel_err_q;
    if (wr_illegal || multi_a || multi_b) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        regs_q[i] <= '0;
      end
      sel_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (wr_legal && wsel[i]) begin
          regs_q[i] <= wdata;
        end
      end
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_regbank_onehot.sv
module tb_regbank_onehot;

  logic        clk;
  logic        reset;
  logic        write;
  logic [7:0]  wsel;
  logic [15:0] wdata;
  logic [7:0]  rsel_a;
  logic [7:0]  rsel_b;
  logic [15:0] rdata_a;
  logic [15:0] rdata_b;
  logic        err_clr;
  logic        sel_err;

  int checks;
  int failures;

  // Reference model: plain array of register values and the sticky flag.
  logic [15:0] model [8];
  logic        model_err;

  regbank_onehot #(
    .K (16),
    .N (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .write   (write),
    .wsel    (wsel),
    .wdata   (wdata),
    .rsel_a  (rsel_a),
    .rsel_b  (rsel_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .err_clr (err_clr),
    .sel_err (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mread(input logic [7:0] sel);
    logic [15:0] v;
    v = 16'h0000;
    if ($countones(sel) == 1) begin
`ifdef REGBANK_BYPASS_EN
      if (write && ($countones(wsel) == 1) && (sel == wsel)) return wdata;
`endif
      for (int i = 0; i < 8; i++) if (sel[i]) v = model[i];
    end
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    model_err = 1'b0;
  endtask

  task automatic drive(input logic w, input logic [7:0] ws, input logic [15:0] wd,
                       input logic [7:0] ra, input logic [7:0] rb, input logic ec);
    write = w; wsel = ws; wdata = wd; rsel_a = ra; rsel_b = rb; err_clr = ec;
  endtask

  // Called at a falling edge with inputs already driven: check reads, clock once,
  // update the model, check the flag, return at the next falling edge.
  task automatic cycle(input string tag);
    logic err_now;
    #1;
    chk({tag, ".rdata_a"}, rdata_a, mread(rsel_a));
    chk({tag, ".rdata_b"}, rdata_b, mread(rsel_b));
    err_now = (write && ($countones(wsel) != 1)) || ($countones(rsel_a) > 1) ||
              ($countones(rsel_b) > 1);
    @(posedge clk);
    if (write && ($countones(wsel) == 1))
      for (int i = 0; i < 8; i++) if (wsel[i]) model[i] = wdata;
    if (err_now) model_err = 1'b1;
    else if (err_clr) model_err = 1'b0;
    #1;
    chk({tag, ".sel_err"}, {15'd0, sel_err}, {15'd0, model_err});
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_clear();
    reset = 1'b1;
    drive(1'b0, 8'h00, 16'h0000, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state for every register.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00, 16'h0000, 8'(1 << i), 8'(1 << (7 - i)), 1'b0);
      #1;
      chk("reset_a", rdata_a, 16'h0000);
      chk("reset_b", rdata_b, 16'h0000);
    end
    chk("reset_err", {15'd0, sel_err}, 16'h0000);

    // Write then read on both ports.
    drive(1'b1, 8'h08, 16'hBEEF, 8'h00, 8'h00, 1'b0);
    cycle("wr_beef");
    drive(1'b0, 8'h00, 16'h0000, 8'h08, 8'h08, 1'b0);
    #1;
    chk("rd_beef_a", rdata_a, 16'hBEEF);
    chk("rd_beef_b", rdata_b, 16'hBEEF);
    cycle("rd_beef");

    // Same-cycle read of the register being written.
    drive(1'b1, 8'h08, 16'h1111, 8'h00, 8'h00, 1'b0);
    cycle("wr_1111");
    drive(1'b1, 8'h08, 16'h2222, 8'h08, 8'h00, 1'b0);
    #1;
`ifdef REGBANK_BYPASS_EN
    chk("same_cycle", rdata_a, 16'h2222);
`else
    chk("same_cycle", rdata_a, 16'h1111);
`endif
    cycle("wr_2222");
    drive(1'b0, 8'h00, 16'h0000, 8'h08, 8'h00, 1'b0);
    #1;
    chk("after_edge", rdata_a, 16'h2222);
    cycle("rd_2222");

    // Illegal multi-hot write leaves R[1], R[2] untouched and latches the flag.
    drive(1'b1, 8'h02, 16'hA1A1, 8'h00, 8'h00, 1'b0);
    cycle("wr_r1");
    drive(1'b1, 8'h04, 16'hB2B2, 8'h00, 8'h00, 1'b0);
    cycle("wr_r2");
    drive(1'b1, 8'h06, 16'hFFFF, 8'h00, 8'h00, 1'b0);
    cycle("ill_wr");
    chk("ill_err", {15'd0, sel_err}, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 16'h0000, 8'h02, 8'h04, 1'b0);
      #1;
      chk("ill_r1", rdata_a, 16'hA1A1);
      chk("ill_r2", rdata_b, 16'hB2B2);
      cycle("ill_idle");
      chk("ill_sticky", {15'd0, sel_err}, 16'h0001);
    end

    // Clear racing a new multi-hot read error: error wins.
    drive(1'b0, 8'h00, 16'h0000, 8'h02, 8'h81, 1'b1);
    #1;
    chk("race_rdb", rdata_b, 16'h0000);
    cycle("race");
    chk("race_err", {15'd0, sel_err}, 16'h0001);
    drive(1'b0, 8'h00, 16'h0000, 8'h02, 8'h04, 1'b1);
    cycle("clear");
    chk("clear_err", {15'd0, sel_err}, 16'h0000);

    // Asynchronous reset with nonzero contents and the flag set.
    drive(1'b0, 8'h00, 16'h0000, 8'h00, 8'h03, 1'b0);
    cycle("set_err");
    drive(1'b0, 8'h00, 16'h0000, 8'h04, 8'h08, 1'b0);
    #1;
    chk("pre_reset", rdata_a, 16'hB2B2);
    reset = 1'b1;
    #1;
    chk("async_rdata", rdata_a, 16'h0000);
    chk("async_err", {15'd0, sel_err}, 16'h0000);
    model_clear();
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset held across the edge of a pending write discards it.
    drive(1'b1, 8'h01, 16'h1234, 8'h00, 8'h00, 1'b0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 8'h00, 16'h0000, 8'h01, 8'h00, 1'b0);
    #1;
    chk("mid_write", rdata_a, 16'h0000);
    cycle("post_reset");

    // Randomised traffic against the model.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] s [3];
      for (int k = 0; k < 3; k++) begin
        int unsigned kind;
        kind = $urandom_range(0, 11);
        if (kind == 0) s[k] = 8'h00;
        else if (kind == 1) s[k] = 8'($urandom);
        else s[k] = 8'(1 << $urandom_range(0, 7));
      end
      drive(1'($urandom), s[0], 16'($urandom), s[1], s[2], ($urandom_range(0, 3) == 0));
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
